// File: rtl/tea_pkg.sv
// rtl/tea_pkg.sv - shared constants, state encoding and byte-order helpers for the TEA/XTEA core
package tea_pkg;

  localparam logic [31:0] DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {NOKEY, IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [63:0] byteswap64_words(input logic [63:0] d);
    return {byteswap32(d[63:32]), byteswap32(d[31:0])};
  endfunction

  function automatic logic [127:0] byteswap128_words(input logic [127:0] d);
    return {byteswap32(d[127:96]), byteswap32(d[95:64]),
            byteswap32(d[63:32]), byteswap32(d[31:0])};
  endfunction

endpackage

// File: rtl/tea_cycle_unit.sv
// rtl/tea_cycle_unit.sv - one combinational TEA/XTEA cipher cycle (two Feistel half-rounds)
module tea_cycle_unit
  import tea_pkg::*;
#(
  parameter bit XTEA_EN = 1'b1
) (
  input  logic [63:0]  v,
  input  logic [127:0] key,
  input  logic [31:0]  sum,
  input  logic         decrypt,
  input  logic         xtea,
  output logic [63:0]  v_next,
  output logic [31:0]  sum_next
);

  logic [31:0] k [4];
  logic [31:0] v0, v1, n0, n1, s1;

  assign k[0] = key[127:96];
  assign k[1] = key[95:64];
  assign k[2] = key[63:32];
  assign k[3] = key[31:0];

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] s,
                                        input logic [31:0] ka, input logic [31:0] kb);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  function automatic logic [31:0] xtea_g(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

  always_comb begin
    v0 = v[63:32];
    v1 = v[31:0];
    n0 = v0;
    n1 = v1;
    s1 = sum;
    if (XTEA_EN && xtea) begin
      if (!decrypt) begin
        n0 = v0 + (xtea_g(v1) ^ (sum + k[sum[1:0]]));
        s1 = sum + DELTA;
        n1 = v1 + (xtea_g(n0) ^ (s1 + k[s1[12:11]]));
      end else begin
        n1 = v1 - (xtea_g(v0) ^ (sum + k[sum[12:11]]));
        s1 = sum - DELTA;
        n0 = v0 - (xtea_g(n1) ^ (s1 + k[s1[1:0]]));
      end
    end else if (!decrypt) begin
      s1 = sum + DELTA;
      n0 = v0 + tea_f(v1, s1, k[0], k[1]);
      n1 = v1 + tea_f(n0, s1, k[2], k[3]);
    end else begin
      // Decrypt undoes v1 first using the pre-decrement sum, mirroring encrypt backwards.
      n1 = v1 - tea_f(v0, sum, k[2], k[3]);
      n0 = v0 - tea_f(n1, sum, k[0], k[1]);
      s1 = sum - DELTA;
    end
  end

  assign v_next   = {n0, n1};
  assign sum_next = s1;

endmodule

// File: rtl/tea_stream_core.sv
// rtl/tea_stream_core.sv - streaming TEA/XTEA engine with key/in/out valid-ready handshakes
module tea_stream_core
  import tea_pkg::*;
#(
  parameter int ROUNDS         = 32,
  parameter int ROUNDS_PER_CLK = 4,
  parameter bit SWAP_BYTES     = 1'b1,
  parameter bit XTEA_EN        = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [63:0]  in_data,
  input  logic         in_decrypt,
  input  logic         in_xtea,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [63:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int STEPS = ROUNDS / ROUNDS_PER_CLK;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [31:0] SUM_DEC = 32'(ROUNDS) * DELTA;

  if ((ROUNDS_PER_CLK < 1) || (ROUNDS % ROUNDS_PER_CLK != 0)) begin : g_param_check
    $error("tea_stream_core: ROUNDS must be a multiple of ROUNDS_PER_CLK");
  end

  state_t         state, state_next;
  logic [127:0]   key_reg, blk_key, key_word;
  logic [63:0]    v_reg, in_word, chain_v;
  logic [31:0]    sum_reg, chain_s;
  logic           dec_reg, xtea_reg, xtea_in;
  logic [CW-1:0]  cnt;
  logic           key_hs, in_hs, out_hs, last_step;

  assign key_word  = SWAP_BYTES ? byteswap128_words(key) : key;
  assign in_word   = SWAP_BYTES ? byteswap64_words(in_data) : in_data;
  assign xtea_in   = XTEA_EN && in_xtea;
  assign key_hs    = key_valid && key_ready;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_step = (cnt == CW'(STEPS - 1));
  assign busy      = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= NOKEY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      NOKEY: begin
        key_ready = 1'b1;
        if (key_valid) state_next = IDLE;
      end
      IDLE: begin
        key_ready = 1'b1;
        in_ready  = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: if (last_step) state_next = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = in_valid ? RUN : IDLE;
      end
      default: state_next = NOKEY;
    endcase
  end

  for (genvar i = 0; i < ROUNDS_PER_CLK; i++) begin : g_stage
    logic [63:0] v_i, v_o;
    logic [31:0] s_i, s_o;
    if (i == 0) begin : g_first
      assign v_i = v_reg;
      assign s_i = sum_reg;
    end else begin : g_next
      assign v_i = g_stage[i-1].v_o;
      assign s_i = g_stage[i-1].s_o;
    end
    tea_cycle_unit #(.XTEA_EN(XTEA_EN)) u_cycle (
      .v        (v_i),
      .key      (blk_key),
      .sum      (s_i),
      .decrypt  (dec_reg),
      .xtea     (xtea_reg),
      .v_next   (v_o),
      .sum_next (s_o)
    );
  end

  assign chain_v = g_stage[ROUNDS_PER_CLK-1].v_o;
  assign chain_s = g_stage[ROUNDS_PER_CLK-1].s_o;

  // blk_key snapshots the stored key at accept, so a key loaded on the same edge only affects later blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg   <= '0;
      blk_key   <= '0;
      v_reg     <= '0;
      sum_reg   <= '0;
      dec_reg   <= 1'b0;
      xtea_reg  <= 1'b0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (key_hs) key_reg <= key_word;
      if (out_hs) out_valid <= 1'b0;
      if (in_hs) begin
        blk_key  <= key_reg;
        v_reg    <= in_word;
        dec_reg  <= in_decrypt;
        xtea_reg <= xtea_in;
        sum_reg  <= in_decrypt ? SUM_DEC : 32'h0;
        cnt      <= '0;
      end else if (state == RUN) begin
        v_reg   <= chain_v;
        sum_reg <= chain_s;
        if (last_step) begin
          out_data  <= SWAP_BYTES ? byteswap64_words(chain_v) : chain_v;
          out_valid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tea_stream_core.sv
// tb/tb_tea_stream_core.sv - scoreboard bench over four core configurations (rpc 4/1/32, byte-swapped)
module tb_tea_stream_core;

  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam logic [127:0] KA = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] KB = 128'hDEADBEEF_0BADF00D_CAFEBABE_13579BDF;
  localparam logic [63:0]  PA = 64'h01234567_89ABCDEF;
  localparam logic [63:0]  PB = 64'hA5A5A5A5_5A5A5A5A;
  localparam logic [63:0]  PC = 64'hFFFFFFFF_00000001;

  logic clk = 1'b0;
  logic reset;
  logic [3:0][127:0] key;
  logic [3:0][63:0]  in_data, out_data;
  logic [3:0] key_valid, key_ready, in_decrypt, in_xtea, in_valid, in_ready;
  logic [3:0] out_valid, out_ready, busy;

  typedef struct {
    int          idx;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RPC = (g == 1) ? 1 : (g == 2) ? 32 : 4;
    localparam bit SW  = (g == 3);
    tea_stream_core #(.ROUNDS(32), .ROUNDS_PER_CLK(RPC), .SWAP_BYTES(SW), .XTEA_EN(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .key        (key[g]),
      .key_valid  (key_valid[g]),
      .key_ready  (key_ready[g]),
      .in_data    (in_data[g]),
      .in_decrypt (in_decrypt[g]),
      .in_xtea    (in_xtea[g]),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .out_data   (out_data[g]),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .busy       (busy[g])
    );
  end

  function automatic int steps(input int idx);
    return (idx == 1) ? 32 : (idx == 2) ? 1 : 8;
  endfunction

  function automatic logic [31:0] bs32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [63:0] bs64(input logic [63:0] d);
    return {bs32(d[63:32]), bs32(d[31:0])};
  endfunction

  function automatic logic [127:0] bs128(input logic [127:0] d);
    return {bs32(d[127:96]), bs32(d[95:64]), bs32(d[63:32]), bs32(d[31:0])};
  endfunction

  // Reference cipher written as the classic 32-iteration software loop.
  function automatic logic [63:0] tea_ref(input logic [127:0] k, input logic [63:0] v,
                                          input bit dec, input bit xt);
    logic [31:0] kw [4];
    logic [31:0] y, z, s;
    kw[0] = k[127:96]; kw[1] = k[95:64]; kw[2] = k[63:32]; kw[3] = k[31:0];
    y = v[63:32];
    z = v[31:0];
    s = dec ? 32'hC6EF3720 : 32'h0;
    for (int r = 0; r < 32; r++) begin
      if (!xt && !dec) begin
        s = s + DELTA;
        y = y + (((z << 4) + kw[0]) ^ (z + s) ^ ((z >> 5) + kw[1]));
        z = z + (((y << 4) + kw[2]) ^ (y + s) ^ ((y >> 5) + kw[3]));
      end else if (!xt) begin
        z = z - (((y << 4) + kw[2]) ^ (y + s) ^ ((y >> 5) + kw[3]));
        y = y - (((z << 4) + kw[0]) ^ (z + s) ^ ((z >> 5) + kw[1]));
        s = s - DELTA;
      end else if (!dec) begin
        y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]));
        s = s + DELTA;
        z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]));
      end else begin
        z = z - ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]));
        s = s - DELTA;
        y = y - ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]));
      end
    end
    return {y, z};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected dut%0d: got %h expected no output", i, out_data[i]);
          end else begin
            e = exp_q.pop_front();
            if (e.idx != i || out_data[i] !== e.data) begin
              n_fail++;
              $display("FAIL sb_data dut%0d: got %h expected %h from dut%0d",
                       i, out_data[i], e.data, e.idx);
            end
          end
        end
      end
    end
  end

  task automatic load_key(input int idx, input logic [127:0] k);
    int t;
    key[idx] = k;
    key_valid[idx] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!key_ready[idx] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("key_ready_wait", 64'(key_ready[idx]), 64'd1);
    @(posedge clk);
    #1 key_valid[idx] = 1'b0;
  endtask

  task automatic send(input int idx, input logic [63:0] d, input bit dec, input bit xt,
                      input bit push, input logic [63:0] e);
    int t;
    in_data[idx] = d;
    in_decrypt[idx] = dec;
    in_xtea[idx] = xt;
    in_valid[idx] = 1'b1;
    if (push) exp_q.push_back('{idx, e});
    t = 0;
    @(negedge clk);
    while (!in_ready[idx] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 64'(in_ready[idx]), 64'd1);
    @(posedge clk);
    #1 in_valid[idx] = 1'b0;
  endtask

  task automatic wait_out(input int idx);
    int cycles;
    cycles = 0;
    while (!out_valid[idx] && cycles < 100) begin
      @(posedge clk);
      #1 cycles++;
    end
    chk($sformatf("latency_dut%0d", idx), 64'(cycles), 64'(steps(idx)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c;
    reset = 1'b1;
    key = '0; in_data = '0;
    key_valid = '0; in_decrypt = '0; in_xtea = '0; in_valid = '0;
    out_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_flags_dut%0d", i),
          64'({key_ready[i], in_ready[i], out_valid[i], busy[i]}), 64'b1000);
      chk($sformatf("rst_out_data_dut%0d", i), out_data[i], 64'h0);
    end

    // Block offered before any key must be ignored
    in_data[0] = PA;
    in_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nokey_in_ready", 64'(in_ready[0]), 64'd0);
      chk("nokey_busy", 64'(busy[0]), 64'd0);
    end
    @(posedge clk);
    #1 in_valid[0] = 1'b0;

    load_key(0, 128'h0);
    send(0, 64'h0, 1'b0, 1'b0, 1'b1, 64'h41EA3A0A_94BAA940);
    chk("busy_after_accept", 64'(busy[0]), 64'd1);
    wait_out(0);
    send(0, 64'h0, 1'b0, 1'b1, 1'b1, 64'hDEE9D4D8_F7131ED9);
    wait_out(0);
    send(0, 64'hDEE9D4D8_F7131ED9, 1'b1, 1'b1, 1'b1, 64'h0);
    wait_out(0);
    send(0, 64'h41EA3A0A_94BAA940, 1'b1, 1'b0, 1'b1, 64'h0);
    wait_out(0);

    // Key and block on the same IDLE edge: block uses the old key
    @(posedge clk);
    #1 key[0] = KA;
    key_valid[0] = 1'b1;
    send(0, PA, 1'b0, 1'b0, 1'b1, tea_ref(128'h0, PA, 1'b0, 1'b0));
    key_valid[0] = 1'b0;
    wait_out(0);
    send(0, PA, 1'b0, 1'b0, 1'b1, tea_ref(KA, PA, 1'b0, 1'b0));
    wait_out(0);

    for (int idx = 0; idx < 3; idx++) begin
      for (int xt = 0; xt < 2; xt++) begin
        load_key(idx, KB);
        c = tea_ref(KB, PB, 1'b0, xt[0]);
        send(idx, PB, 1'b0, xt[0], 1'b1, c);
        wait_out(idx);
        send(idx, c, 1'b1, xt[0], 1'b1, PB);
        wait_out(idx);
      end
    end

    // Backpressure, then back-to-back output+input handshake
    repeat (2) @(posedge clk);
    #1 out_ready[0] = 1'b0;
    c = tea_ref(KB, PC, 1'b0, 1'b1);
    send(0, PC, 1'b0, 1'b1, 1'b1, c);
    wait_out(0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_data", out_data[0], c);
      chk("bp_flags", 64'({out_valid[0], in_ready[0], key_ready[0]}), 64'b100);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    send(0, PA, 1'b0, 1'b0, 1'b1, tea_ref(KB, PA, 1'b0, 1'b0));
    chk("b2b_flags", 64'({busy[0], out_valid[0]}), 64'b10);
    wait_out(0);

    // Reset mid-RUN discards the block and the key
    send(0, PB, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_run_flags", 64'({key_ready[0], in_ready[0], out_valid[0], busy[0]}), 64'b1000);
    in_data[0] = PA;
    in_valid[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_accept", 64'({in_ready[0], busy[0]}), 64'b00);
    end
    @(posedge clk);
    #1;
    load_key(0, KA);
    send(0, PA, 1'b0, 1'b0, 1'b1, tea_ref(KA, PA, 1'b0, 1'b0));
    wait_out(0);

    // Byte-swapped word layout
    load_key(3, 128'h0);
    send(3, 64'h0, 1'b0, 1'b0, 1'b1, 64'h0A3AEA41_40A9BA94);
    wait_out(3);
    load_key(3, bs128(KA));
    send(3, bs64(PA), 1'b0, 1'b1, 1'b1, bs64(tea_ref(KA, PA, 1'b0, 1'b1)));
    wait_out(3);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
